blackjack_round_ctrl: RTL and testbench

//   Sequences one blackjack round between player and dealer. Pulls cards from an upstream card

---
 rtl/blackjack_pkg.sv | 48 ++++
 rtl/blackjack_round_ctrl_hand_accum.sv | 68 ++++++
 rtl/blackjack_round_ctrl.sv | 229 ++++++++++++++++++++++
 tb/tb_blackjack_round_ctrl.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/blackjack_pkg.sv
// Shared types, constants and card helpers for the blackjack round controller.
package blackjack_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    DEAL    = 3'd1,
    CHECK   = 3'd2,
    PLAYER  = 3'd3,
    DEALER  = 3'd4,
    RESOLVE = 3'd5,
    DONE    = 3'd6
  } state_t;

  localparam logic [1:0] RES_NONE   = 2'b00;
  localparam logic [1:0] RES_PLAYER = 2'b01;
  localparam logic [1:0] RES_DEALER = 2'b10;
  localparam logic [1:0] RES_PUSH   = 2'b11;

  localparam logic [4:0] BJ_21     = 5'd21;
  localparam logic [4:0] FACE_VAL  = 5'd10;
  localparam logic [4:0] ACE_BONUS = 5'd10;

  function automatic logic card_illegal(input logic [3:0] v);
    return (v == 4'd0) || (v > 4'd13);
  endfunction

  // Hard-total contribution: faces count as ten, ace counts one.
  function automatic logic [4:0] card_points(input logic [3:0] v);
    logic [4:0] pts;
    if (v >= 4'd10) begin
      pts = FACE_VAL;
    end else begin
      pts = {1'b0, v};
    end
    return pts;
  endfunction

  function automatic logic [4:0] effective_total(input logic [4:0] hard, input logic ace);
    logic [4:0] eff;
    if (ace && (hard <= 5'd11)) begin
      eff = hard + ACE_BONUS;
    end else begin
      eff = hard;
    end
    return eff;
  endfunction

endpackage

// File: rtl/blackjack_round_ctrl_hand_accum.sv
// One hand's running state: hard total, ace flag, card count and the registered effective total.
module hand_accum
  import blackjack_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       add,
  input  logic [3:0] value,
  output logic [4:0] hard,
  output logic       ace,
  output logic [2:0] count,
  output logic [4:0] total
);

  logic [4:0] hard_r;
  logic [4:0] hard_nxt_s;
  logic       ace_r;
  logic       ace_nxt_s;
  logic [2:0] count_r;
  logic [2:0] count_nxt_s;
  logic [4:0] total_r;

  // Next hand contents; count saturates so long dealer runs of low cards cannot wrap.
  always_comb begin
    hard_nxt_s  = hard_r;
    ace_nxt_s   = ace_r;
    count_nxt_s = count_r;
    if (clr) begin
      hard_nxt_s  = 5'd0;
      ace_nxt_s   = 1'b0;
      count_nxt_s = 3'd0;
    end else if (add) begin
      hard_nxt_s  = hard_r + card_points(value);
      ace_nxt_s   = ace_r | (value == 4'd1);
      if (count_r == 3'd7) begin
        count_nxt_s = count_r;
      end else begin
        count_nxt_s = count_r + 3'd1;
      end
    end else begin
      hard_nxt_s  = hard_r;
      ace_nxt_s   = ace_r;
      count_nxt_s = count_r;
    end
  end

  // Hand registers; the effective total is registered alongside the hard total.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hard_r  <= 5'd0;
      ace_r   <= 1'b0;
      count_r <= 3'd0;
      total_r <= 5'd0;
    end else begin
      hard_r  <= hard_nxt_s;
      ace_r   <= ace_nxt_s;
      count_r <= count_nxt_s;
      total_r <= effective_total(hard_nxt_s, ace_nxt_s);
    end
  end

  assign hard  = hard_r;
  assign ace   = ace_r;
  assign count = count_r;
  assign total = total_r;

endmodule

// File: rtl/blackjack_round_ctrl.sv
// Blackjack round sequencer: deal, player hit/stand, dealer auto-draw and outcome resolution.
module blackjack_round_ctrl
  import blackjack_pkg::*;
#(
  parameter int DEALER_STAND = 17,
  parameter int MAX_CARDS    = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       hit,
  input  logic       stand,
  input  logic       card_valid,
  input  logic [3:0] card_value,
  output logic       card_req,
  output logic [4:0] player_total,
  output logic [4:0] dealer_total,
  output logic [2:0] player_cards,
  output logic [2:0] state,
  output logic       done,
  output logic [1:0] result,
  output logic       bad_card
);

  localparam logic [4:0] STAND_L = 5'(DEALER_STAND);
  localparam logic [2:0] MAX_L   = 3'(MAX_CARDS);

  state_t     state_r;
  state_t     state_nxt_s;
  logic [1:0] deal_idx_r;
  logic [1:0] deal_idx_nxt_s;
  logic       pending_r;
  logic       pending_nxt_s;
  logic       card_req_r;
  logic       card_req_nxt_s;
  logic [1:0] result_r;
  logic [1:0] result_nxt_s;
  logic       done_r;
  logic       bad_card_r;

  logic       xfer_s;
  logic       legal_s;
  logic       clr_s;
  logic       p_add_s;
  logic       d_add_s;

  logic [4:0] p_hard_s;
  logic       p_ace_s;
  logic [2:0] p_cards_s;
  logic [4:0] p_eff_s;
  logic [4:0] d_hard_s;
  logic       d_ace_s;
  logic [2:0] d_cards_s;
  logic [4:0] d_eff_s;

  logic       p_bust_s;
  logic       d_bust_s;
  logic       p_nat_s;
  logic       d_nat_s;

  assign xfer_s  = card_req_r & card_valid;
  assign legal_s = ~card_illegal(card_value);

  // A two-card 21 is exactly an ace plus a ten-value card: hard 11 with the ace flag.
  assign p_bust_s = (p_hard_s > BJ_21);
  assign d_bust_s = (d_hard_s > BJ_21);
  assign p_nat_s  = (p_cards_s == 3'd2) && p_ace_s && (p_hard_s == 5'd11);
  assign d_nat_s  = (d_cards_s == 3'd2) && d_ace_s && (d_hard_s == 5'd11);

  hand_accum u_player (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr_s),
    .add   (p_add_s),
    .value (card_value),
    .hard  (p_hard_s),
    .ace   (p_ace_s),
    .count (p_cards_s),
    .total (p_eff_s)
  );

  hand_accum u_dealer (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr_s),
    .add   (d_add_s),
    .value (card_value),
    .hard  (d_hard_s),
    .ace   (d_ace_s),
    .count (d_cards_s),
    .total (d_eff_s)
  );

  // Next-state, hand update strobes, hit-pending flag and outcome.
  always_comb begin
    state_nxt_s    = state_r;
    deal_idx_nxt_s = deal_idx_r;
    pending_nxt_s  = pending_r;
    result_nxt_s   = result_r;
    clr_s          = 1'b0;
    p_add_s        = 1'b0;
    d_add_s        = 1'b0;
    case (state_r)
      IDLE, DONE: begin
        if (start) begin
          state_nxt_s    = DEAL;
          clr_s          = 1'b1;
          deal_idx_nxt_s = 2'd0;
          pending_nxt_s  = 1'b0;
          result_nxt_s   = RES_NONE;
        end else begin
          state_nxt_s = state_r;
        end
      end
      DEAL: begin
        if (xfer_s && legal_s) begin
          p_add_s        = ~deal_idx_r[0];
          d_add_s        = deal_idx_r[0];
          deal_idx_nxt_s = deal_idx_r + 2'd1;
          if (deal_idx_r == 2'd3) begin
            state_nxt_s = CHECK;
          end else begin
            state_nxt_s = DEAL;
          end
        end else begin
          state_nxt_s = DEAL;
        end
      end
      CHECK: begin
        pending_nxt_s = 1'b0;
        if (p_eff_s == BJ_21) begin
          state_nxt_s = RESOLVE;
        end else begin
          state_nxt_s = PLAYER;
        end
      end
      PLAYER: begin
        // Totals are re-checked every cycle, so a new card is judged the cycle after it lands.
        if (p_bust_s) begin
          state_nxt_s   = RESOLVE;
          pending_nxt_s = 1'b0;
        end else if ((p_eff_s == BJ_21) || (p_cards_s == MAX_L)) begin
          state_nxt_s   = DEALER;
          pending_nxt_s = 1'b0;
        end else if (stand) begin
          state_nxt_s   = DEALER;
          pending_nxt_s = 1'b0;
        end else if (xfer_s && legal_s) begin
          p_add_s       = 1'b1;
          pending_nxt_s = 1'b0;
        end else if (hit && !pending_r) begin
          pending_nxt_s = 1'b1;
        end else begin
          pending_nxt_s = pending_r;
        end
      end
      DEALER: begin
        if (d_eff_s >= STAND_L) begin
          state_nxt_s = RESOLVE;
        end else begin
          state_nxt_s = DEALER;
          d_add_s     = xfer_s && legal_s;
        end
      end
      RESOLVE: begin
        state_nxt_s = DONE;
        if (p_bust_s) begin
          result_nxt_s = RES_DEALER;
        end else if (p_nat_s) begin
          result_nxt_s = d_nat_s ? RES_PUSH : RES_PLAYER;
        end else if (d_bust_s) begin
          result_nxt_s = RES_PLAYER;
        end else if (p_eff_s > d_eff_s) begin
          result_nxt_s = RES_PLAYER;
        end else if (p_eff_s < d_eff_s) begin
          result_nxt_s = RES_DEALER;
        end else begin
          result_nxt_s = RES_PUSH;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // card_req is registered, so it is derived from where the FSM goes next; after a dealer
  // card it drops for one cycle while the new total is evaluated.
  always_comb begin
    card_req_nxt_s = 1'b0;
    case (state_nxt_s)
      DEAL:    card_req_nxt_s = 1'b1;
      PLAYER:  card_req_nxt_s = pending_nxt_s;
      DEALER:  card_req_nxt_s = ~d_add_s && (d_eff_s < STAND_L);
      default: card_req_nxt_s = 1'b0;
    endcase
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= IDLE;
      deal_idx_r <= 2'd0;
      pending_r  <= 1'b0;
      card_req_r <= 1'b0;
      result_r   <= RES_NONE;
      done_r     <= 1'b0;
      bad_card_r <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      deal_idx_r <= deal_idx_nxt_s;
      pending_r  <= pending_nxt_s;
      card_req_r <= card_req_nxt_s;
      result_r   <= result_nxt_s;
      done_r     <= (state_nxt_s == DONE);
      bad_card_r <= xfer_s & ~legal_s;
    end
  end

  assign card_req     = card_req_r;
  assign player_total = p_eff_s;
  assign dealer_total = d_eff_s;
  assign player_cards = p_cards_s;
  assign state        = state_r;
  assign done         = done_r;
  assign result       = result_r;
  assign bad_card     = bad_card_r;

endmodule

// File: tb/tb_blackjack_round_ctrl.sv
// Directed bench for blackjack_round_ctrl: a table of full rounds plus hand-written corner sequences.
module tb_blackjack_round_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       hit;
  logic       stand;
  logic       card_valid;
  logic [3:0] card_value;
  logic       card_req;
  logic [4:0] player_total;
  logic [4:0] dealer_total;
  logic [2:0] player_cards;
  logic [2:0] state;
  logic       done;
  logic [1:0] result;
  logic       bad_card;

  int n_vec = 0;
  int n_bad = 0;
  int xfer_total = 0;

  blackjack_round_ctrl #(.DEALER_STAND(17), .MAX_CARDS(5)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .hit          (hit),
    .stand        (stand),
    .card_valid   (card_valid),
    .card_value   (card_value),
    .card_req     (card_req),
    .player_total (player_total),
    .dealer_total (dealer_total),
    .player_cards (player_cards),
    .state        (state),
    .done         (done),
    .result       (result),
    .bad_card     (bad_card)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (card_req === 1'b1 && card_valid === 1'b1) xfer_total <= xfer_total + 1;
  end

  // Cards are nibbles, first card in bits [3:0].
  typedef struct packed {
    logic [15:0] deal;
    logic [2:0]  n_hit;
    logic [15:0] hits;
    logic        do_stand;
    logic [2:0]  n_dlr;
    logic [15:0] dlr;
    logic [1:0]  res;
    logic [4:0]  p;
    logic [4:0]  d;
    logic [2:0]  pc;
  } vec_t;

  vec_t vecs [0:10];

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic give_card(input logic [3:0] v, input string name);
    int w = 0;
    while (card_req !== 1'b1 && w < 40) begin
      @(negedge clk);
      w++;
    end
    if (card_req !== 1'b1) begin
      n_vec++;
      n_bad++;
      $display("FAIL %s: card_req never rose, got %b, expected 1", name, card_req);
    end else begin
      card_valid = 1'b1;
      card_value = v;
      @(negedge clk);
      card_valid = 1'b0;
      card_value = 4'd0;
    end
  endtask

  task automatic wait_state(input logic [2:0] s, input string name);
    int w = 0;
    while (state !== s && w < 40) begin
      @(negedge clk);
      w++;
    end
    if (state !== s) begin
      n_vec++;
      n_bad++;
      $display("FAIL %s: state stuck at %0d, expected %0d", name, state, s);
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic do_hit();
    hit = 1'b1;
    @(negedge clk);
    hit = 1'b0;
  endtask

  task automatic do_stand();
    stand = 1'b1;
    @(negedge clk);
    stand = 1'b0;
  endtask

  task automatic deal4(input logic [15:0] cards, input string name);
    for (int k = 0; k < 4; k++) give_card(cards[k*4 +: 4], name);
  endtask

  task automatic run_round(input vec_t v, input int idx);
    int base;
    base = xfer_total;
    do_start();
    deal4(v.deal, $sformatf("v%0d deal", idx));
    if (v.n_hit != 3'd0 || v.do_stand) wait_state(3'd3, $sformatf("v%0d to PLAYER", idx));
    for (int k = 0; k < int'(v.n_hit); k++) begin
      do_hit();
      give_card(v.hits[k*4 +: 4], $sformatf("v%0d hit %0d", idx, k));
    end
    if (v.do_stand) do_stand();
    for (int k = 0; k < int'(v.n_dlr); k++) give_card(v.dlr[k*4 +: 4], $sformatf("v%0d dealer %0d", idx, k));
    wait_state(3'd6, $sformatf("v%0d to DONE", idx));
    chk($sformatf("v%0d done", idx), int'(done), 1);
    chk($sformatf("v%0d result", idx), int'(result), int'(v.res));
    chk($sformatf("v%0d player_total", idx), int'(player_total), int'(v.p));
    chk($sformatf("v%0d dealer_total", idx), int'(dealer_total), int'(v.d));
    chk($sformatf("v%0d player_cards", idx), int'(player_cards), int'(v.pc));
    chk($sformatf("v%0d transfers", idx), xfer_total - base, 4 + int'(v.n_hit) + int'(v.n_dlr));
  endtask

  initial begin
    int base;
    vecs[0]  = '{deal:16'hA97A, n_hit:3'd0, hits:16'h0000, do_stand:1'b1, n_dlr:3'd0, dlr:16'h0000, res:2'b01, p:5'd19, d:5'd17, pc:3'd2};
    vecs[1]  = '{deal:16'h7D91, n_hit:3'd0, hits:16'h0000, do_stand:1'b0, n_dlr:3'd0, dlr:16'h0000, res:2'b01, p:5'd21, d:5'd16, pc:3'd2};
    vecs[2]  = '{deal:16'hAC11, n_hit:3'd0, hits:16'h0000, do_stand:1'b0, n_dlr:3'd0, dlr:16'h0000, res:2'b11, p:5'd21, d:5'd21, pc:3'd2};
    vecs[3]  = '{deal:16'hA56A, n_hit:3'd1, hits:16'h0009, do_stand:1'b0, n_dlr:3'd0, dlr:16'h0000, res:2'b10, p:5'd24, d:5'd16, pc:3'd3};
    vecs[4]  = '{deal:16'h671A, n_hit:3'd0, hits:16'h0000, do_stand:1'b1, n_dlr:3'd0, dlr:16'h0000, res:2'b11, p:5'd17, d:5'd17, pc:3'd2};
    vecs[5]  = '{deal:16'h62A2, n_hit:3'd3, hits:16'h0232, do_stand:1'b0, n_dlr:3'd1, dlr:16'h0005, res:2'b10, p:5'd11, d:5'd21, pc:3'd5};
    vecs[6]  = '{deal:16'h68AA, n_hit:3'd0, hits:16'h0000, do_stand:1'b1, n_dlr:3'd1, dlr:16'h000A, res:2'b01, p:5'd18, d:5'd26, pc:3'd2};
    vecs[7]  = '{deal:16'h76A5, n_hit:3'd1, hits:16'h000A, do_stand:1'b0, n_dlr:3'd0, dlr:16'h0000, res:2'b01, p:5'd21, d:5'd17, pc:3'd3};
    vecs[8]  = '{deal:16'h97AA, n_hit:3'd0, hits:16'h0000, do_stand:1'b1, n_dlr:3'd0, dlr:16'h0000, res:2'b10, p:5'd17, d:5'd19, pc:3'd2};
    vecs[9]  = '{deal:16'h55A1, n_hit:3'd1, hits:16'h000A, do_stand:1'b1, n_dlr:3'd1, dlr:16'h0002, res:2'b10, p:5'd16, d:5'd17, pc:3'd3};
    vecs[10] = '{deal:16'h591A, n_hit:3'd0, hits:16'h0000, do_stand:1'b1, n_dlr:3'd2, dlr:16'h003A, res:2'b11, p:5'd19, d:5'd19, pc:3'd2};

    rst = 1'b0;
    start = 1'b0;
    hit = 1'b0;
    stand = 1'b0;
    card_valid = 1'b0;
    card_value = 4'd0;
    repeat (3) @(negedge clk);
    chk("reset outputs", int'({card_req, player_total, dealer_total, player_cards, state, done, result, bad_card}), 0);
    rst = 1'b1;
    @(negedge clk);
    chk("idle after reset", int'(state), 0);

    for (int i = 0; i <= 10; i++) run_round(vecs[i], i);

    // Hit and stand together: stand wins, no player card.
    do_start();
    deal4(16'hA37A, "hs deal");
    wait_state(3'd3, "hs to PLAYER");
    hit = 1'b1;
    stand = 1'b1;
    @(negedge clk);
    hit = 1'b0;
    stand = 1'b0;
    chk("hs state DEALER", int'(state), 4);
    chk("hs card_req", int'(card_req), 0);
    chk("hs player_cards", int'(player_cards), 2);
    wait_state(3'd6, "hs to DONE");
    chk("hs result", int'(result), 2);

    // Hit ignored in DEAL; stand cancels a pending hit.
    do_start();
    do_hit();
    deal4(16'hA37A, "cancel deal");
    wait_state(3'd3, "cancel to PLAYER");
    chk("hit in DEAL ignored", int'(card_req), 0);
    do_hit();
    chk("pending raises card_req", int'(card_req), 1);
    do_stand();
    chk("cancel state DEALER", int'(state), 4);
    chk("cancel card_req", int'(card_req), 0);
    chk("cancel player_cards", int'(player_cards), 2);
    wait_state(3'd6, "cancel to DONE");
    chk("cancel result", int'(result), 2);
    chk("cancel player_total", int'(player_total), 13);

    // Stalled source, illegal card, then reset in the middle of the dealer's draw.
    do_start();
    repeat (5) @(negedge clk);
    chk("stall state DEAL", int'(state), 1);
    chk("stall card_req", int'(card_req), 1);
    chk("stall player_cards", int'(player_cards), 0);
    give_card(4'd0, "bad card 0");
    chk("bad_card pulse", int'(bad_card), 1);
    chk("bad card hand unchanged", int'(player_cards), 0);
    chk("bad card keeps card_req", int'(card_req), 1);
    @(negedge clk);
    chk("bad_card one cycle", int'(bad_card), 0);
    deal4(16'h576A, "post-bad deal");
    wait_state(3'd3, "post-bad to PLAYER");
    chk("post-bad player_total", int'(player_total), 17);
    chk("post-bad dealer_total", int'(dealer_total), 11);
    do_stand();
    chk("dealer wants card", int'(card_req), 1);
    card_valid = 1'b1;
    card_value = 4'd5;
    rst = 1'b0;
    #1;
    chk("mid-round reset outputs", int'({card_req, player_total, dealer_total, player_cards, state, done, result, bad_card}), 0);
    base = xfer_total;
    @(negedge clk);
    chk("no transfer in reset", xfer_total - base, 0);
    card_valid = 1'b0;
    card_value = 4'd0;
    rst = 1'b1;
    @(negedge clk);
    chk("idle after mid reset", int'({card_req, player_total, dealer_total, player_cards, state, done, result, bad_card}), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
